readout_rx_state_decision_unit_multi_ch: RTL and testbench

//  Multi-channel, parametrised successor to the single-qubit IQ-histogram state decision unit.

---
 rtl/readout_rx_state_decision_unit_multi_ch_if.sv | 47 ++++
 rtl/readout_rx_state_decision_unit_multi_ch.sv | 204 ++++++++++++++++++++
 tb/tb_readout_rx_state_decision_unit_multi_ch.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_rx_state_decision_unit_multi_ch_if.sv
// Handshake/bus bundle for the multi-channel readout state decision unit.
// The master side drives config, count control and samples; the slave side returns results.
interface readout_rx_state_decision_unit_multi_ch_if #(
   parameter int NUM_CH            = 4,
   parameter int CH_ID_WIDTH       = 2,
   parameter int DATA_WIDTH        = 16,
   parameter int BIN_BITS          = 2,
   parameter int BIN_COUNTER_WIDTH = 10
);
   localparam int NUM_BINS    = 1 << (2 * BIN_BITS);
   localparam int SCORE_WIDTH = BIN_COUNTER_WIDTH + 2 * BIN_BITS + 1;

   logic                          cfg_we;
   logic [CH_ID_WIDTH-1:0]        cfg_ch;
   logic [NUM_BINS-1:0]           cfg_mask;
   logic [SCORE_WIDTH-1:0]        cfg_thresh;
   logic [NUM_CH-1:0]             start_count;
   logic [NUM_CH-1:0]             finish_count;
   logic                          valid_in;
   logic [CH_ID_WIDTH-1:0]        ch_in;
   logic [DATA_WIDTH-1:0]         i_in;
   logic [DATA_WIDTH-1:0]         q_in;
   logic                          valid_meas_result_out;
   logic [CH_ID_WIDTH-1:0]        meas_ch_out;
   logic                          meas_result_out;
   logic [SCORE_WIDTH-1:0]        meas_score_out;
   logic                          meas_ovf_out;
   logic                          busy_out;

   modport master (
      output cfg_we, cfg_ch, cfg_mask, cfg_thresh,
      output start_count, finish_count,
      output valid_in, ch_in, i_in, q_in,
      input  valid_meas_result_out, meas_ch_out,
      input  meas_result_out, meas_score_out,
      input  meas_ovf_out, busy_out
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_mask, cfg_thresh,
      input  start_count, finish_count,
      input  valid_in, ch_in, i_in, q_in,
      output valid_meas_result_out, meas_ch_out,
      output meas_result_out, meas_score_out,
      output meas_ovf_out, busy_out
   );
endinterface

// File: rtl/readout_rx_state_decision_unit_multi_ch.sv
// Per-channel coarse IQ histograms plus one shared ROI scan engine producing signed scores.
// Define READOUT_RX_SDU_SAT_EN for saturating bin counters with a sticky overflow flag.
module readout_rx_state_decision_unit_multi_ch #(
   parameter int NUM_CH            = 4,
   parameter int CH_ID_WIDTH       = 2,
   parameter int DATA_WIDTH        = 16,
   parameter int BIN_BITS          = 2,
   parameter int BIN_COUNTER_WIDTH = 10
) (
   input  logic clk,
   input  logic rst_n,
   readout_rx_state_decision_unit_multi_ch_if.slave bus
);
   localparam int NUM_BINS = 1 << (2 * BIN_BITS);
   localparam int SW       = BIN_COUNTER_WIDTH + 2 * BIN_BITS + 1;
   localparam int BW       = 2 * BIN_BITS;
   localparam int IW       = BW + 1;
   localparam int CNTW     = BIN_COUNTER_WIDTH;
   localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] CH_IDLE  = 2'd0;
   localparam logic [1:0] CH_COUNT = 2'd1;
   localparam logic [1:0] CH_PEND  = 2'd2;
   localparam logic [1:0] CH_SCAN  = 2'd3;

   localparam logic [1:0] EN_IDLE = 2'd0;
   localparam logic [1:0] EN_SCAN = 2'd1;
   localparam logic [1:0] EN_DONE = 2'd2;

   logic [1:0]             ch_st  [NUM_CH];
   logic [NUM_BINS-1:0]    mask   [NUM_CH];
   logic signed [SW-1:0]   thresh [NUM_CH];
   logic [CNTW-1:0]        cnt    [NUM_CH][NUM_BINS];

   logic [1:0]             en_st;
   logic [CH_ID_WIDTH-1:0] en_ch;
   logic [IW-1:0]          en_idx;
   logic [NUM_BINS-1:0]    en_mask;
   logic signed [SW-1:0]   en_thr;
   logic signed [SW-1:0]   en_score;

   logic                   res_vld;
   logic [CH_ID_WIDTH-1:0] res_ch;
   logic                   res_bit;
   logic signed [SW-1:0]   res_score;

   // Offset-binary conversion only touches the top bits, so flip just the sign bit.
   logic [BIN_BITS-1:0]    i_top;
   logic [BIN_BITS-1:0]    q_top;
   logic [BW-1:0]          s_bin;

   assign i_top = bus.i_in[DATA_WIDTH-1 -: BIN_BITS]
                ^ (BIN_BITS'(1) << (BIN_BITS - 1));
   assign q_top = bus.q_in[DATA_WIDTH-1 -: BIN_BITS]
                ^ (BIN_BITS'(1) << (BIN_BITS - 1));
   assign s_bin = {i_top, q_top};

   logic                   gnt_vld;
   logic [CH_ID_WIDTH-1:0] gnt_ch;
   logic                   gnt;
   logic                   scan_last;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (ch_st[c] == CH_PEND) begin
            gnt_vld = 1'b1;
            gnt_ch  = CH_ID_WIDTH'(c);
         end
      end
   end

   assign gnt       = gnt_vld && (en_st != EN_SCAN);
   assign scan_last = (en_st == EN_SCAN) && (en_idx == IW'(NUM_BINS));

   logic [CNTW-1:0]        cur_cnt;
   logic [SW-1:0]          cnt_x;
   logic signed [SW-1:0]   term;

   assign cur_cnt = cnt[en_ch[CW-1:0]][en_idx[BW-1:0]];
   assign cnt_x   = {{(SW - CNTW){1'b0}}, cur_cnt};
   assign term    = en_mask[en_idx[BW-1:0]] ? signed'(cnt_x)
                                            : signed'(~cnt_x + SW'(1));

`ifdef READOUT_RX_SDU_SAT_EN
   logic [NUM_CH-1:0]      ovf;
   logic                   res_ovf;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_st     <= EN_IDLE;
         en_ch     <= '0;
         en_idx    <= '0;
         en_mask   <= '0;
         en_thr    <= '0;
         en_score  <= '0;
         res_vld   <= 1'b0;
         res_ch    <= '0;
         res_bit   <= 1'b0;
         res_score <= '0;
`ifdef READOUT_RX_SDU_SAT_EN
         res_ovf   <= 1'b0;
`endif
      end else begin
         res_vld <= 1'b0;
         if (en_st == EN_SCAN) begin
            if (scan_last) begin
               res_vld   <= 1'b1;
               res_ch    <= en_ch;
               res_bit   <= (en_score >= en_thr);
               res_score <= en_score;
`ifdef READOUT_RX_SDU_SAT_EN
               res_ovf   <= ovf[en_ch[CW-1:0]];
`endif
               en_st     <= EN_DONE;
            end else begin
               en_score <= en_score + term;
               en_idx   <= en_idx + IW'(1);
            end
         end else if (gnt) begin
            en_st    <= EN_SCAN;
            en_ch    <= gnt_ch;
            en_idx   <= '0;
            en_score <= '0;
            en_mask  <= mask[gnt_ch[CW-1:0]];
            en_thr   <= thresh[gnt_ch[CW-1:0]];
         end else begin
            en_st <= EN_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ch_st[c]  <= CH_IDLE;
            mask[c]   <= '1;
            thresh[c] <= '0;
            for (int b = 0; b < NUM_BINS; b++) cnt[c][b] <= '0;
         end
`ifdef READOUT_RX_SDU_SAT_EN
         ovf <= '0;
`endif
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.cfg_we && bus.cfg_ch == CH_ID_WIDTH'(c)) begin
               mask[c]   <= bus.cfg_mask;
               thresh[c] <= signed'(bus.cfg_thresh);
            end

            unique case (ch_st[c])
               CH_IDLE, CH_COUNT: begin
                  if (bus.start_count[c]) begin
                     ch_st[c] <= CH_COUNT;
                     for (int b = 0; b < NUM_BINS; b++) cnt[c][b] <= '0;
`ifdef READOUT_RX_SDU_SAT_EN
                     ovf[c] <= 1'b0;
`endif
                  end else if (ch_st[c] == CH_COUNT && bus.finish_count[c]) begin
                     ch_st[c] <= CH_PEND;
                  end
               end
               CH_PEND: begin
                  if (gnt && gnt_ch == CH_ID_WIDTH'(c)) ch_st[c] <= CH_SCAN;
               end
               default: begin
                  if (scan_last && en_ch == CH_ID_WIDTH'(c)) begin
                     ch_st[c] <= CH_IDLE;
                     for (int b = 0; b < NUM_BINS; b++) cnt[c][b] <= '0;
`ifdef READOUT_RX_SDU_SAT_EN
                     ovf[c] <= 1'b0;
`endif
                  end
               end
            endcase

            // A start on the same cycle clears the bins, so that sample is dropped.
            if (bus.valid_in && bus.ch_in == CH_ID_WIDTH'(c)
                && ch_st[c] == CH_COUNT && !bus.start_count[c]) begin
`ifdef READOUT_RX_SDU_SAT_EN
               if (&cnt[c][s_bin]) ovf[c] <= 1'b1;
               else cnt[c][s_bin] <= cnt[c][s_bin] + CNTW'(1);
`else
               cnt[c][s_bin] <= cnt[c][s_bin] + CNTW'(1);
`endif
            end
         end
      end
   end

   assign bus.valid_meas_result_out = res_vld;
   assign bus.meas_ch_out           = res_ch;
   assign bus.meas_result_out       = res_bit;
   assign bus.meas_score_out        = res_score;
   assign bus.busy_out              = (en_st != EN_IDLE);
`ifdef READOUT_RX_SDU_SAT_EN
   assign bus.meas_ovf_out          = res_ovf;
`else
   assign bus.meas_ovf_out          = 1'b0;
`endif

endmodule

// File: tb/tb_readout_rx_state_decision_unit_multi_ch.sv
// Bench for the multi-channel state decision unit: directed scenarios plus random traffic
// compared every cycle against a transaction-level histogram/score model.
module tb_readout_rx_state_decision_unit_multi_ch;
   localparam int NUM_CH = 4;
   localparam int CIW    = 3;
   localparam int DW     = 16;
   localparam int BB     = 2;
   localparam int BCW    = 3;
   localparam int NB     = 1 << (2 * BB);
   localparam int SW     = BCW + 2 * BB + 1;
   localparam int CMAX   = (1 << BCW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   readout_rx_state_decision_unit_multi_ch_if #(
      .NUM_CH(NUM_CH), .CH_ID_WIDTH(CIW), .DATA_WIDTH(DW),
      .BIN_BITS(BB), .BIN_COUNTER_WIDTH(BCW)
   ) bus ();

   readout_rx_state_decision_unit_multi_ch #(
      .NUM_CH(NUM_CH), .CH_ID_WIDTH(CIW), .DATA_WIDTH(DW),
      .BIN_BITS(BB), .BIN_COUNTER_WIDTH(BCW)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // model: 0 idle, 1 counting, 2 pending, 3 being scanned
   int          m_st  [NUM_CH];
   int          m_h   [NUM_CH][NB];
   bit          m_ov  [NUM_CH];
   bit [NB-1:0] m_mask[NUM_CH];
   int          m_thr [NUM_CH];
   int          m_left, m_ch, m_sc;
   bit          m_r;
   bit          e_valid, e_r, e_o;
   int          e_ch, e_sc;
   int          pst[NUM_CH];
   int          pleft, g, sch, sb;

   function automatic int bin_of(logic [DW-1:0] i, logic [DW-1:0] q);
      int ii, qq;
      ii = (int'($signed(i)) + (1 << (DW - 1))) >> (DW - BB);
      qq = (int'($signed(q)) + (1 << (DW - 1))) >> (DW - BB);
      return ii * (1 << BB) + qq;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = 0; m_ov[c] = 0; m_mask[c] = '1; m_thr[c] = 0;
            for (int b = 0; b < NB; b++) m_h[c][b] = 0;
         end
         m_left = 0; m_ch = 0; m_sc = 0; m_r = 0;
         e_valid = 0; e_ch = 0; e_sc = 0; e_r = 0; e_o = 0;
      end else begin
         pst = m_st;
         pleft = m_left;
         e_valid = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               e_valid = 1; e_ch = m_ch; e_sc = m_sc; e_r = m_r; e_o = m_ov[m_ch];
               m_st[m_ch] = 0; m_ov[m_ch] = 0;
               for (int b = 0; b < NB; b++) m_h[m_ch][b] = 0;
            end
         end
         if (pleft == 0) begin
            g = -1;
            for (int c = 0; c < NUM_CH; c++) if (pst[c] == 2 && g < 0) g = c;
            if (g >= 0) begin
               m_ch = g; m_sc = 0;
               for (int b = 0; b < NB; b++)
                  m_sc += m_mask[g][b] ? m_h[g][b] : -m_h[g][b];
               m_r = (m_sc >= m_thr[g]);
               m_st[g] = 3;
               m_left = NB + 1;
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.start_count[c] && pst[c] <= 1) begin
               m_st[c] = 1; m_ov[c] = 0;
               for (int b = 0; b < NB; b++) m_h[c][b] = 0;
            end else if (bus.finish_count[c] && pst[c] == 1) begin
               m_st[c] = 2;
            end
         end
         sch = int'(bus.ch_in);
         if (bus.valid_in && sch < NUM_CH) begin
            if (pst[sch] == 1 && !bus.start_count[sch]) begin
               sb = bin_of(bus.i_in, bus.q_in);
`ifdef READOUT_RX_SDU_SAT_EN
               if (m_h[sch][sb] == CMAX) m_ov[sch] = 1;
               else m_h[sch][sb]++;
`else
               m_h[sch][sb] = (m_h[sch][sb] + 1) % (CMAX + 1);
`endif
            end
         end
         if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH) begin
            m_mask[bus.cfg_ch] = bus.cfg_mask;
            m_thr[bus.cfg_ch]  = int'($signed(bus.cfg_thresh));
         end
      end
   end

   logic [SW-1:0]  x_sc;
   logic [CIW-1:0] x_ch;
   logic           x_busy;
   always @(negedge clk) begin
      if (rst_n) begin
         x_sc   = SW'(e_sc);
         x_ch   = CIW'(e_ch);
         x_busy = (m_left > 0) || e_valid;
         checks++;
         if (bus.valid_meas_result_out !== e_valid || bus.busy_out !== x_busy
             || bus.meas_ch_out !== x_ch || bus.meas_result_out !== e_r
             || bus.meas_score_out !== x_sc || bus.meas_ovf_out !== e_o) begin
            failures++;
            if (failures < 30)
               $display("FAIL cycle_cmp t=%0t got v=%b b=%b ch=%0d r=%b sc=%0d o=%b want v=%b b=%b ch=%0d r=%b sc=%0d o=%b",
                  $time, bus.valid_meas_result_out, bus.busy_out, bus.meas_ch_out,
                  bus.meas_result_out, $signed(bus.meas_score_out), bus.meas_ovf_out,
                  e_valid, x_busy, e_ch, e_r, e_sc, e_o);
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.cfg_we = 0; bus.start_count = '0; bus.finish_count = '0; bus.valid_in = 0;
   endtask

   task automatic cyc();
      @(posedge clk); #1; idle_inputs();
   endtask

   task automatic cfg(int ch, logic [NB-1:0] m, int th);
      bus.cfg_we = 1; bus.cfg_ch = CIW'(ch); bus.cfg_mask = m; bus.cfg_thresh = SW'(th);
      cyc();
   endtask

   task automatic start(int ch);
      bus.start_count[ch] = 1'b1; cyc();
   endtask

   task automatic finish(int ch);
      bus.finish_count[ch] = 1'b1; cyc();
   endtask

   task automatic samp(int ch, logic [DW-1:0] i, logic [DW-1:0] q, int n);
      repeat (n) begin
         bus.valid_in = 1; bus.ch_in = CIW'(ch); bus.i_in = i; bus.q_in = q;
         cyc();
      end
   endtask

   task automatic wait_valid(string nm, output int at);
      bit seen = 0;
      at = -1;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (bus.valid_meas_result_out === 1'b1) begin seen = 1; at = cyc_cnt; end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL %s timeout waiting for result", nm); end
   endtask

   task automatic wait_busy(string nm, output int at);
      bit seen = 0;
      at = -1;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (bus.busy_out === 1'b1) begin seen = 1; at = cyc_cnt; end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL %s timeout waiting for busy", nm); end
   endtask

   task automatic chk_res(string nm, int ch, int sc, int r);
      chk({nm, "_ch"}, int'(bus.meas_ch_out), ch);
      chk({nm, "_score"}, int'($signed(bus.meas_score_out)), sc);
      chk({nm, "_result"}, int'(bus.meas_result_out), r);
   endtask

   int t_g, t_v, t_v2, nv;

   initial begin
      idle_inputs();
      bus.cfg_ch = '0; bus.cfg_mask = '0; bus.cfg_thresh = '0;
      bus.ch_in = '0; bus.i_in = '0; bus.q_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", int'(bus.valid_meas_result_out), 0);
      chk("reset_busy", int'(bus.busy_out), 0);
      chk("reset_score", int'(bus.meas_score_out), 0);
      @(posedge clk); #1 rst_n = 1;

      // reset in the middle of a scan
      start(0); samp(0, 16'h0000, 16'h0000, 1); finish(0);
      wait_busy("rst_grant", t_g);
      @(posedge clk); #1 rst_n = 0;
      @(negedge clk);
      chk("midrst_busy", int'(bus.busy_out), 0);
      chk("midrst_valid", int'(bus.valid_meas_result_out), 0);
      chk("midrst_score", int'(bus.meas_score_out), 0);
      chk("midrst_ch", int'(bus.meas_ch_out), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      nv = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.valid_meas_result_out === 1'b1) nv++;
      end
      chk("midrst_no_valid", nv, 0);
      cyc();
      start(0); samp(0, 16'h0000, 16'h0000, 1); finish(0);
      wait_valid("after_rst", t_v);
      chk_res("after_rst", 0, 1, 1);

      // ROI mask 00FF: 3 in-ROI, 5 out-of-ROI samples
      cyc();
      cfg(0, 16'h00FF, 0); start(0);
      samp(0, 16'hC000, 16'h0000, 3); samp(0, 16'h4000, 16'h0000, 5);
      finish(0);
      wait_busy("roi_grant", t_g);
      wait_valid("roi", t_v);
      chk("roi_latency", t_v - t_g, 17);
      chk_res("roi", 0, -2, 0);

      cyc();
      cfg(0, 16'h00FF, -2); start(0);
      samp(0, 16'hC000, 16'h0000, 3); samp(0, 16'h4000, 16'h0000, 5);
      finish(0);
      wait_valid("thr_m2", t_v);
      chk_res("thr_m2", 0, -2, 1);

      cyc();
      cfg(0, 16'h00FF, 0); start(0); finish(0);
      wait_valid("empty", t_v);
      chk_res("empty", 0, 0, 1);

      // simultaneous finish on ch1/ch2, ch3 counting meanwhile
      cyc();
      bus.start_count = 4'b1110; cyc();
      samp(1, 16'h0000, 16'h0000, 2); samp(2, 16'h0000, 16'h0000, 4);
      bus.finish_count = 4'b0110; cyc();
      samp(3, 16'h0000, 16'h0000, 5);
      wait_valid("arb_ch1", t_v);
      chk_res("arb_ch1", 1, 2, 1);
      cyc();
      samp(3, 16'h0000, 16'h0000, 1);
      wait_valid("arb_ch2", t_v2);
      chk_res("arb_ch2", 2, 4, 1);
      chk("arb_gap", t_v2 - t_v, 18);
      cyc();
      finish(3);
      wait_valid("arb_ch3", t_v);
      chk_res("arb_ch3", 3, 6, 1);

      // restart while counting; idle-channel and out-of-range samples dropped
      cyc();
      cfg(0, '1, 0); start(0);
      samp(0, 16'h0000, 16'h0000, 4);
      start(0);
      samp(0, 16'hC000, 16'h0000, 1);
      samp(1, 16'h0000, 16'h0000, 2); samp(5, 16'h0000, 16'h0000, 2);
      finish(0);
      wait_valid("restart", t_v);
      chk_res("restart", 0, 1, 1);
      cyc();
      start(1); finish(1);
      wait_valid("idle_drop", t_v);
      chk_res("idle_drop", 1, 0, 1);

      // overflow of one bin with 9 samples
      cyc();
      start(3); samp(3, 16'h0000, 16'h0000, 9); finish(3);
      wait_valid("ovf", t_v);
`ifdef READOUT_RX_SDU_SAT_EN
      chk_res("ovf", 3, 7, 1);
      chk("ovf_flag", int'(bus.meas_ovf_out), 1);
`else
      chk_res("ovf", 3, 1, 1);
      chk("ovf_flag", int'(bus.meas_ovf_out), 0);
`endif

      // random traffic checked by the model each cycle
      cyc();
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(19) == 0) begin
            bus.cfg_we = 1; bus.cfg_ch = CIW'($urandom_range(7));
            bus.cfg_mask = NB'($urandom); bus.cfg_thresh = SW'($urandom);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            bus.start_count[c]  = ($urandom_range(39) == 0);
            bus.finish_count[c] = ($urandom_range(14) == 0);
         end
         bus.valid_in = ($urandom_range(3) != 0);
         bus.ch_in = CIW'($urandom_range(7));
         bus.i_in = DW'($urandom); bus.q_in = DW'($urandom);
         cyc();
      end
      bus.finish_count = '1; cyc();
      repeat (NUM_CH * (NB + 2) + 10) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
